// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: FSM state encodings, flush-counter width and
// the default flush length used by hazard_ctrl.
package hazard_ctrl_pkg;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned FCNT_W           = 3;
    localparam int unsigned STATE_W          = 2;
    localparam int unsigned REG_W            = 5;

    // Encoding 2'd3 is illegal and is steered back to ST_RUN.
    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: flags when the load in EX writes a non-x0
// register that the instruction in IF/ID reads.
// Ports:
//   de_memrd, de_ctrl_regwr  - EX instruction is a register-writing load
//   de_wr_reg[5:0]           - EX destination (bits [4:0] compared)
//   f_rs1, f_rs2, f_uses_rs2 - IF/ID source fields and rs2 usage
//   hazard                   - combinational hazard flag
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic             de_memrd,
    input  logic             de_ctrl_regwr,
    input  logic [5:0]       de_wr_reg,
    input  logic [REG_W-1:0] f_rs1,
    input  logic [REG_W-1:0] f_rs2,
    input  logic             f_uses_rs2,
    output logic             hazard
);

    logic [REG_W-1:0] wr_reg;
    logic             unused_wr_msb;

    assign wr_reg        = de_wr_reg[REG_W-1:0];
    assign unused_wr_msb = de_wr_reg[5];

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = de_memrd && de_ctrl_regwr && (wr_reg != '0) &&
                    ((wr_reg == f_rs1) || (f_uses_rs2 && (wr_reg == f_rs2)));

endmodule

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter used for the stall and flush statistics.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   inc_i    - count one event this cycle
//   cnt_o    - current count, sticks at all-ones
module hazard_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// whole-pipe freeze on data-memory wait, with saturating event counters.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   de_memrd, de_ctrl_regwr,
//   de_wr_reg                 - load in EX
//   f_rs1, f_rs2, f_uses_rs2  - source operands of IF/ID instruction
//   ex_branch_taken           - branch resolved taken in EX
//   mem_busy                  - data memory stall, freeze the pipeline
//   d_stall, pc_write, ifid_write, ifid_flush, pipe_hold
//                             - combinational pipeline controls
//   state                     - current FSM state
//   stall_cnt, flush_cnt      - load-use bubble / branch flush counts
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_memrd,
    input  logic               de_ctrl_regwr,
    input  logic [5:0]         de_wr_reg,
    input  logic [REG_W-1:0]   f_rs1,
    input  logic [REG_W-1:0]   f_rs2,
    input  logic               f_uses_rs2,
    input  logic               ex_branch_taken,
    input  logic               mem_busy,
    output logic               d_stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               pipe_hold,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    hz_state_e         state_q;
    hz_state_e         ret_q;
    hz_state_e         eff_state;
    logic [FCNT_W-1:0] fcnt_q;
    logic              hazard;
    logic              stall_inc;
    logic              flush_inc;

    hazard_cmp u_cmp (
        .de_memrd      (de_memrd),
        .de_ctrl_regwr (de_ctrl_regwr),
        .de_wr_reg     (de_wr_reg),
        .f_rs1         (f_rs1),
        .f_rs2         (f_rs2),
        .f_uses_rs2    (f_uses_rs2),
        .hazard        (hazard)
    );

    // Leaving MEMWAIT, the cycle behaves as the saved state would.
    assign eff_state = (state_q == ST_MEMWAIT) ? ret_q : state_q;

    // Combinational controls and counter increment strobes.
    always_comb begin
        d_stall    = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            d_stall    = 1'b1;
            ifid_flush = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else begin
            case (eff_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        d_stall    = 1'b1;
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (hazard) begin
                        d_stall    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        stall_inc  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Load-use is irrelevant: the dependent instruction is being squashed.
                    d_stall    = 1'b1;
                    ifid_flush = 1'b1;
                    flush_inc  = ex_branch_taken;
                end
                default: ;
            endcase
        end
    end

    // State, saved return state and flush countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            fcnt_q  <= '0;
        end else if (!(state_q inside {ST_RUN, ST_FLUSH, ST_MEMWAIT})) begin
            state_q <= ST_RUN;
        end else if (mem_busy) begin
            // Keep the original return state across back-to-back wait cycles.
            if (state_q != ST_MEMWAIT) begin
                ret_q <= state_q;
            end
            state_q <= ST_MEMWAIT;
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    if (ex_branch_taken) begin
                        fcnt_q  <= FLUSH_LOAD;
                        state_q <= ST_FLUSH;
                    end else if (fcnt_q <= FCNT_W'(1)) begin
                        fcnt_q  <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        fcnt_q  <= fcnt_q - FCNT_W'(1);
                        state_q <= ST_FLUSH;
                    end
                end
                default: begin
                    if (ex_branch_taken) begin
                        fcnt_q  <= FLUSH_LOAD;
                        state_q <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt)
    );

    assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       de_memrd;
    logic       de_ctrl_regwr;
    logic [5:0] de_wr_reg;
    logic [4:0] f_rs1;
    logic [4:0] f_rs2;
    logic       f_uses_rs2;
    logic       ex_branch_taken;
    logic       mem_busy;

    logic        d_stall, pc_write, ifid_write, ifid_flush, pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_d_stall, s_pc_write, s_ifid_write, s_ifid_flush, s_pipe_hold;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Control vector order: {d_stall, pc_write, ifid_write, ifid_flush, pipe_hold}
    localparam logic [4:0] C_IDLE   = 5'b01100;
    localparam logic [4:0] C_LU     = 5'b10000;
    localparam logic [4:0] C_FLUSH  = 5'b11110;
    localparam logic [4:0] C_FREEZE = 5'b00001;
    localparam logic [4:0] C_RESET  = 5'b10010;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .de_memrd        (de_memrd),
        .de_ctrl_regwr   (de_ctrl_regwr),
        .de_wr_reg       (de_wr_reg),
        .f_rs1           (f_rs1),
        .f_rs2           (f_rs2),
        .f_uses_rs2      (f_uses_rs2),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .d_stall         (d_stall),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .pipe_hold       (pipe_hold),
        .state           (state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .de_memrd        (de_memrd),
        .de_ctrl_regwr   (de_ctrl_regwr),
        .de_wr_reg       (de_wr_reg),
        .f_rs1           (f_rs1),
        .f_rs2           (f_rs2),
        .f_uses_rs2      (f_uses_rs2),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .d_stall         (s_d_stall),
        .pc_write        (s_pc_write),
        .ifid_write      (s_ifid_write),
        .ifid_flush      (s_ifid_flush),
        .pipe_hold       (s_pipe_hold),
        .state           (s_state),
        .stall_cnt       (s_stall_cnt),
        .flush_cnt       (s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, 32'({d_stall, pc_write, ifid_write, ifid_flush, pipe_hold}), 32'(exp));
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        de_memrd        = 1'b0;
        de_ctrl_regwr   = 1'b0;
        de_wr_reg       = 6'd0;
        f_rs1           = 5'd0;
        f_rs2           = 5'd0;
        f_uses_rs2      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
    endtask

    task automatic set_lu(input logic [5:0] wr, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic uses2);
        de_memrd      = 1'b1;
        de_ctrl_regwr = 1'b1;
        de_wr_reg     = wr;
        f_rs1         = rs1;
        f_rs2         = rs2;
        f_uses_rs2    = uses2;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        #1;
        check_ctl("reset_ctl", C_RESET);
        check("reset_state", 32'(state), 32'd0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);

        rst = 1'b0;
        #1;
        check_ctl("idle_ctl", C_IDLE);

        // Single load-use bubble
        set_lu(6'd5, 5'd5, 5'd0, 1'b0);
        #1;
        check_ctl("lu_ctl", C_LU);
        check("lu_state", 32'(state), 32'd0);
        tick();
        clear_in();
        #1;
        check_ctl("lu_after_ctl", C_IDLE);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // x0 destination and rs2 gating, combinational only
        set_lu(6'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_ctl("x0_ctl", C_IDLE);
        set_lu(6'd7, 5'd3, 5'd7, 1'b0);
        #1;
        check_ctl("rs2_unused_ctl", C_IDLE);
        f_uses_rs2 = 1'b1;
        #1;
        check_ctl("rs2_used_ctl", C_LU);
        tick();
        set_lu(6'h25, 5'd5, 5'd0, 1'b0);
        #1;
        check_ctl("wr_msb_ignored_ctl", C_LU);
        clear_in();
        #1;
        check("rs2_stall_cnt", 32'(stall_cnt), 32'd2);

        // Taken branch: two flush cycles, hazard ignored while flushing
        ex_branch_taken = 1'b1;
        #1;
        check_ctl("br0_ctl", C_FLUSH);
        tick();
        clear_in();
        set_lu(6'd5, 5'd5, 5'd0, 1'b0);
        #1;
        check("br1_state", 32'(state), 32'd1);
        check_ctl("br1_ctl", C_FLUSH);
        check("br1_flush_cnt", 32'(flush_cnt), 32'd1);
        tick();
        clear_in();
        #1;
        check("br2_state", 32'(state), 32'd0);
        check_ctl("br2_ctl", C_IDLE);
        check("br_stall_cnt", 32'(stall_cnt), 32'd2);

        // Freeze during the second flush cycle
        ex_branch_taken = 1'b1;
        tick();
        clear_in();
        mem_busy = 1'b1;
        #1;
        check("frz_enter_state", 32'(state), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_ctl("frz_ctl", C_FREEZE);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        check("frz_wait_state", 32'(state), 32'd2);
        check_ctl("frz_resume_ctl", C_FLUSH);
        check("frz_flush_cnt", 32'(flush_cnt), 32'd2);
        tick();
        #1;
        check("frz_done_state", 32'(state), 32'd0);
        check_ctl("frz_done_ctl", C_IDLE);

        // Load-use, branch and mem_busy together: freeze wins, nothing counted
        set_lu(6'd5, 5'd5, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        mem_busy        = 1'b1;
        #1;
        check_ctl("prio_ctl", C_FREEZE);
        tick();
        clear_in();
        #1;
        check("prio_state", 32'(state), 32'd2);
        check("prio_stall_cnt", 32'(stall_cnt), 32'd2);
        check("prio_flush_cnt", 32'(flush_cnt), 32'd2);
        check_ctl("prio_resume_ctl", C_IDLE);
        tick();
        #1;
        check("prio_back_state", 32'(state), 32'd0);

        // Branch again while flushing reloads the countdown
        ex_branch_taken = 1'b1;
        tick();
        #1;
        check("reload_state", 32'(state), 32'd1);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("reload_still_flush", 32'(state), 32'd1);
        check("reload_flush_cnt", 32'(flush_cnt), 32'd4);
        tick();
        #1;
        check("reload_done_state", 32'(state), 32'd0);

        // Reset in the middle of a flush
        ex_branch_taken = 1'b1;
        tick();
        clear_in();
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(state), 32'd1);
        check_ctl("rst_mid_ctl", C_RESET);
        tick();
        rst = 1'b0;
        #1;
        check("rst_after_state", 32'(state), 32'd0);
        check("rst_after_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_after_flush_cnt", 32'(flush_cnt), 32'd0);
        check_ctl("rst_after_ctl", C_IDLE);

        // Five load-use events: narrow counter saturates at 3
        set_lu(6'd9, 5'd9, 5'd0, 1'b0);
        repeat (5) tick();
        clear_in();
        #1;
        check("sat_wide_stall_cnt", 32'(stall_cnt), 32'd5);
        check("sat_narrow_stall_cnt", 32'(s_stall_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of consecutive flush cycles after a taken branch (legal range 1..7).
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk (input, 1, rising-edge) and rst (input, 1, synchronous active-high reset).
REQ-004 de_memrd  input  1  memory-read control bit of the instruction in EX (ID/EX output).
REQ-005 de_ctrl_regwr  input  1  register-write control bit of the instruction in EX.
REQ-006 de_wr_reg  input  6  destination register of the instruction in EX; only bits [4:0] are compared.
REQ-007 f_rs1  input  5  rs1 field of the instruction in IF/ID.
REQ-008 f_rs2  input  5  rs2 field of the instruction in IF/ID.
REQ-009 f_uses_rs2  input  1  the instruction in IF/ID reads rs2.
REQ-010 ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-011 mem_busy  input  1  data memory not ready; the whole pipeline must freeze.
REQ-012 d_stall  output  1  insert bubble: ID/EX control fields become invalid.
REQ-013 pc_write  output  1  PC update enable.
REQ-014 ifid_write  output  1  IF/ID load enable.
REQ-015 ifid_flush  output  1  clear IF/ID to NOP.
REQ-016 pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-017 state  output  2  current FSM state.
REQ-018 stall_cnt  output  CNT_W  count of load-use bubbles inserted.
REQ-019 flush_cnt  output  CNT_W  count of taken-branch flush events.

Function
REQ-020 FSM states: RUN=0, FLUSH=1, MEMWAIT=2. Encoding 3 is illegal and SHALL go to RUN on the next clock edge.
REQ-021 Outputs SHALL be combinational in the current state and inputs. State and counters SHALL update only on the rising edge of clk.
REQ-022 Default (RUN, no event): d_stall=0, pc_write=1, ifid_write=1, ifid_flush=0, pipe_hold=0.
REQ-023 Event priority: rst > mem_busy > ex_branch_taken > load-use hazard.
REQ-024 Load-use hazard is true when all of the following hold: de_memrd=1; de_ctrl_regwr=1; de_wr_reg[4:0]!=0; and either de_wr_reg[4:0]==f_rs1, or f_uses_rs2=1 and de_wr_reg[4:0]==f_rs2.
REQ-025 In RUN with a load-use hazard, the block SHALL set d_stall=1, pc_write=0, ifid_write=0 for that cycle only, and stall_cnt SHALL increment by 1. The state SHALL remain RUN.
REQ-026 In RUN with ex_branch_taken=1, the block SHALL set d_stall=1 and ifid_flush=1. It SHALL load the flush counter with FLUSH_CYCLES-1 and increment flush_cnt. The next state SHALL be FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-027 In FLUSH, the block SHALL assert d_stall=1 and ifid_flush=1 and decrement the flush counter. It SHALL return to RUN on the edge where the counter is 0. Load-use hazards SHALL be ignored in FLUSH.
REQ-028 A new ex_branch_taken in FLUSH SHALL reload the counter to FLUSH_CYCLES-1 and increment flush_cnt.
REQ-029 mem_busy=1 in any state SHALL force pc_write=0, ifid_write=0, pipe_hold=1, d_stall=0 and ifid_flush=0 in the same cycle.
REQ-030 On mem_busy=1, the FSM SHALL enter MEMWAIT and save the return state and flush counter. The flush counter and the counters SHALL not change while mem_busy=1.
REQ-031 In MEMWAIT with mem_busy=0, the FSM SHALL resume the saved state. Outputs in that cycle SHALL follow that state's rules, including events present in that cycle.
REQ-032 A branch or load-use event coincident with mem_busy=1 SHALL be ignored. It is re-evaluated after the freeze because EX holds.
REQ-033 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-034 While rst=1, outputs SHALL be d_stall=1, ifid_flush=1, pc_write=0, ifid_write=0, pipe_hold=0.
REQ-035 On a clock edge with rst=1: state=RUN, flush counter=0, saved state=RUN, stall_cnt=0, flush_cnt=0. Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon that state.

Structure
REQ-036 State encodings, the RUN/FLUSH/MEMWAIT constants and the default FLUSH_CYCLES SHALL live in the shared pipeline package.
REQ-037 The register-compare logic SHALL be one sub-module, hazard_cmp (inputs: de_memrd, de_ctrl_regwr, de_wr_reg, f_rs1, f_rs2, f_uses_rs2; output: hazard).
REQ-038 The two saturating counters SHALL share one counter sub-module instantiated twice.

Verification
REQ-039 Load-use: de_memrd=1, de_ctrl_regwr=1, de_wr_reg=5, f_rs1=5 for one cycle -> d_stall=1, pc_write=0, ifid_write=0 that cycle only; stall_cnt 0->1.
REQ-040 x0 and rs2 gating: de_wr_reg=0, f_rs1=0 -> no stall. de_wr_reg=7, f_rs2=7, f_uses_rs2=0 -> no stall; f_uses_rs2=1 -> stall.
REQ-041 Branch: ex_branch_taken=1 with FLUSH_CYCLES=2 -> ifid_flush=1 and d_stall=1 for exactly 2 cycles; state RUN->FLUSH->RUN; flush_cnt=1.
REQ-042 Freeze mid-flush: mem_busy=1 for 3 cycles during the second FLUSH cycle -> pipe_hold=1 for 3 cycles, then one more flush cycle, then RUN.
REQ-043 Priority and reset: load-use, branch and mem_busy in the same cycle -> only freeze outputs. rst=1 during FLUSH -> next cycle state=RUN and both counters=0.
REQ-044 Saturation: CNT_W=2 with 5 load-use events -> stall_cnt=3.
